// File: rtl/pmem_arbiter.sv
// Two-master arbiter sharing one physical-memory port between I and D caches.
// Grants alternate on contention; one transaction is held until pmem_resp.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic                  i_pmem_resp,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic                  d_pmem_resp,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        SERVE_I,
        SERVE_D
    } state_t;

    state_t state, state_nx;

    logic                  last_d;
    logic                  i_req, d_req;
    logic                  grant_i, grant_d;
    logic                  serving;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wr_q;
    logic [LINE_WIDTH-1:0] wdata_q;
    logic [LINE_WIDTH-1:0] i_rdata_q;
    logic [LINE_WIDTH-1:0] d_rdata_q;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // On contention the master that was not granted last wins
    assign grant_i = (state == IDLE) & i_req & (~d_req | last_d);
    assign grant_d = (state == IDLE) & d_req & ~grant_i;

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (grant_i) begin
                    state_nx = SERVE_I;
                end else if (grant_d) begin
                    state_nx = SERVE_D;
                end
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_d  <= 1'b1;
            addr_q  <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (grant_i) begin
            last_d  <= 1'b0;
            addr_q  <= i_pmem_address;
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (grant_d) begin
            last_d  <= 1'b1;
            addr_q  <= d_pmem_address;
            wr_q    <= d_pmem_write;
            wdata_q <= d_pmem_wdata;
        end
    end

    // Each master sees its last returned line while the other is served
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else if (pmem_resp) begin
            if (state == SERVE_I) begin
                i_rdata_q <= pmem_rdata;
            end
            if (state == SERVE_D) begin
                d_rdata_q <= pmem_rdata;
            end
        end
    end

    assign serving = (state != IDLE);

    assign pmem_read    = serving & ~wr_q;
    assign pmem_write   = serving & wr_q;
    assign pmem_address = serving ? addr_q : '0;
    assign pmem_wdata   = (serving & wr_q) ? wdata_q : '0;

    assign i_pmem_resp  = (state == SERVE_I) & pmem_resp;
    assign d_pmem_resp  = (state == SERVE_D) & pmem_resp;
    assign i_pmem_rdata = (state == SERVE_I) ? pmem_rdata : i_rdata_q;
    assign d_pmem_rdata = (state == SERVE_D) ? pmem_rdata : d_rdata_q;

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: directed masters, a 3-cycle memory
// model, and a monitor that checks every pmem transaction and master resp.
module tb_pmem_arbiter;

    logic         clk = 1'b0;
    logic         reset;
    logic         i_pmem_read;
    logic [15:0]  i_pmem_address;
    logic         i_pmem_resp;
    logic [127:0] i_pmem_rdata;
    logic         d_pmem_read;
    logic         d_pmem_write;
    logic [15:0]  d_pmem_address;
    logic [127:0] d_pmem_wdata;
    logic         d_pmem_resp;
    logic [127:0] d_pmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    pmem_arbiter #(.ADDR_WIDTH(16), .LINE_WIDTH(128)) dut (
        .clk(clk),
        .reset(reset),
        .i_pmem_read(i_pmem_read),
        .i_pmem_address(i_pmem_address),
        .i_pmem_resp(i_pmem_resp),
        .i_pmem_rdata(i_pmem_rdata),
        .d_pmem_read(d_pmem_read),
        .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address),
        .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_resp(d_pmem_resp),
        .d_pmem_rdata(d_pmem_rdata),
        .pmem_read(pmem_read),
        .pmem_write(pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata),
        .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_d;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wdata;
        logic [127:0] rdata;
    } exp_t;

    exp_t exp_pmem[$];
    exp_t exp_resp[$];
    exp_t cur;

    int  npass = 0;
    int  ntot  = 0;
    bit  mem_en = 1'b1;
    bit  in_x = 1'b0;
    int  cnt = 0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    task automatic expect_x(bit is_d, bit wr, logic [15:0] a, logic [127:0] wd, bit resp);
        exp_t e;
        e.is_d  = is_d;
        e.wr    = wr;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = {8{a}};
        exp_pmem.push_back(e);
        if (resp) exp_resp.push_back(e);
    endtask

    task automatic req(bit is_d, bit wr, logic [15:0] a, logic [127:0] wd);
        if (is_d) begin
            d_pmem_read    = ~wr;
            d_pmem_write   = wr;
            d_pmem_address = a;
            d_pmem_wdata   = wd;
        end else begin
            i_pmem_read    = 1'b1;
            i_pmem_address = a;
        end
    endtask

    // Master side: wait for its resp, then drop the request next cycle
    task automatic wait_done(bit is_d);
        int n = 0;
        @(negedge clk);
        while (!(is_d ? d_pmem_resp : i_pmem_resp) && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            ntot++;
            $display("FAIL timeout_%s: got no resp expected resp", is_d ? "d" : "i");
        end
        @(posedge clk);
        #2;
        if (is_d) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end else begin
            i_pmem_read = 1'b0;
        end
    endtask

    // Memory model: resp in the third strobe cycle, line = address repeated
    initial begin
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (pmem_resp) begin
                pmem_resp  = 1'b0;
                pmem_rdata = '0;
            end else if (mem_en && (pmem_read || pmem_write)) begin
                cnt++;
                if (cnt == 3) begin
                    cnt        = 0;
                    pmem_resp  = 1'b1;
                    pmem_rdata = {8{pmem_address}};
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((pmem_read || pmem_write) && !in_x) begin
                in_x = 1'b1;
                if (exp_pmem.size() == 0) begin
                    ntot++;
                    $display("FAIL unexpected_strobe: got addr %h expected none", pmem_address);
                    cur.wr = pmem_write;
                    cur.addr = pmem_address;
                    cur.wdata = pmem_wdata;
                end else begin
                    cur = exp_pmem.pop_front();
                end
            end
            if (pmem_read || pmem_write) begin
                chk("pmem_address", pmem_address, cur.addr);
                chk("pmem_write", pmem_write, cur.wr);
                if (cur.wr) chk("pmem_wdata", pmem_wdata, cur.wdata);
            end else begin
                in_x = 1'b0;
            end
            if (i_pmem_resp || d_pmem_resp) begin
                if (exp_resp.size() == 0) begin
                    ntot++;
                    $display("FAIL unexpected_resp: got i=%b d=%b expected none",
                             i_pmem_resp, d_pmem_resp);
                end else begin
                    e = exp_resp.pop_front();
                    chk("d_pmem_resp", d_pmem_resp, e.is_d);
                    chk("i_pmem_resp", i_pmem_resp, !e.is_d);
                    if (e.is_d) chk("d_pmem_rdata", d_pmem_rdata, e.rdata);
                    else chk("i_pmem_rdata", i_pmem_rdata, e.rdata);
                end
            end
        end
    end

    initial begin
        reset          = 1'b1;
        i_pmem_read    = 1'b0;
        i_pmem_address = '0;
        d_pmem_read    = 1'b0;
        d_pmem_write   = 1'b0;
        d_pmem_address = '0;
        d_pmem_wdata   = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_i_rdata", i_pmem_rdata, 0);
        chk("rst_d_resp", d_pmem_resp, 0);
        @(posedge clk);
        #2;
        reset = 1'b0;

        // I-only read with one-cycle grant latency
        @(posedge clk);
        #2;
        expect_x(0, 0, 16'h1230, '0, 1);
        req(0, 0, 16'h1230, '0);
        @(negedge clk);
        chk("lat_cycle_n", pmem_read, 0);
        @(negedge clk);
        chk("lat_cycle_n1", pmem_read, 1);
        wait_done(0);

        // D write-back; wdata changed mid-transfer must not reach pmem
        expect_x(1, 1, 16'h4560, {16{8'hA5}}, 1);
        req(1, 1, 16'h4560, {16{8'hA5}});
        @(negedge clk);
        @(negedge clk);
        d_pmem_wdata = {128{1'b1}};
        wait_done(1);

        // Contention with last grant D: I then D, twice
        for (int k = 0; k < 2; k++) begin
            expect_x(0, 0, 16'h2000 + 16'(k * 16), '0, 1);
            expect_x(1, 0, 16'h3000 + 16'(k * 16), '0, 1);
            req(0, 0, 16'h2000 + 16'(k * 16), '0);
            req(1, 0, 16'h3000 + 16'(k * 16), '0);
            fork
                wait_done(0);
                wait_done(1);
            join
        end

        // Last grant I, then contention: D wins first
        expect_x(0, 0, 16'h5000, '0, 1);
        req(0, 0, 16'h5000, '0);
        wait_done(0);
        expect_x(1, 0, 16'h6000, '0, 1);
        expect_x(0, 0, 16'h5010, '0, 1);
        req(1, 0, 16'h6000, '0);
        req(0, 0, 16'h5010, '0);
        fork
            wait_done(0);
            wait_done(1);
        join

        // Back-to-back I misses: exactly one idle cycle between strobes
        expect_x(0, 0, 16'h7000, '0, 1);
        req(0, 0, 16'h7000, '0);
        wait_done(0);
        expect_x(0, 0, 16'h7010, '0, 1);
        req(0, 0, 16'h7010, '0);
        @(negedge clk);
        chk("gap_low", pmem_read, 0);
        @(negedge clk);
        chk("gap_high", pmem_read, 1);
        wait_done(0);

        // Reset during SERVE_D, then a stray pmem_resp in IDLE
        mem_en = 1'b0;
        expect_x(1, 0, 16'h8000, '0, 0);
        req(1, 0, 16'h8000, '0);
        @(negedge clk);
        @(negedge clk);
        chk("serve_d_before_rst", pmem_read, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_read", pmem_read, 0);
        chk("async_rst_write", pmem_write, 0);
        chk("async_rst_address", pmem_address, 0);
        chk("async_rst_d_resp", d_pmem_resp, 0);
        chk("async_rst_d_rdata", d_pmem_rdata, 0);
        d_pmem_read = 1'b0;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(posedge clk);
        #2;
        pmem_resp = 1'b1;
        pmem_rdata = {8{16'hDEAD}};
        @(negedge clk);
        chk("stray_i_resp", i_pmem_resp, 0);
        chk("stray_d_resp", d_pmem_resp, 0);
        chk("stray_idle_read", pmem_read, 0);
        @(posedge clk);
        #2;
        mem_en = 1'b1;

        // After reset: D alone works, then contention favours I again
        expect_x(1, 0, 16'h9000, '0, 1);
        req(1, 0, 16'h9000, '0);
        wait_done(1);
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        expect_x(0, 0, 16'hA000, '0, 1);
        expect_x(1, 1, 16'hB000, {8{16'h5A5A}}, 1);
        req(0, 0, 16'hA000, '0);
        req(1, 1, 16'hB000, {8{16'h5A5A}});
        fork
            wait_done(0);
            wait_done(1);
        join

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("exp_pmem_drained", 128'(exp_pmem.size()), 0);
        chk("exp_resp_drained", 128'(exp_resp.size()), 0);
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got hang expected completion");
        $fatal(1, "timeout");
    end

endmodule
